note_scroll_sched: RTL and testbench

Sequencer for the two-lane note LED display. It fetches 32-bit note words per lane from the song store and advances the 5-bit scroll index at a fixed tick rate. It drives next_note1/2 and next_idx1/2 of the display stage, and only runs in game mode 2. It sits between the song ROM interface and the display register stage.

---
 rtl/note_scroll_sched.sv | 158 +++++++++++++++
 tb/tb_note_scroll_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_scroll_sched.sv
// -----------------------------------------------------------------------------
// note_scroll_sched
// Sequencer for the two-lane note LED display. It fetches one 32-bit note word
// per lane from the song store, then steps a shared 5-bit scroll index once
// every TICK_DIV clocks. It is active only in game mode 2.
//
// Optional feature macro: LOOP_EN
//   defined   : after the last step of word SONG_LEN-1 the address wraps to 0
//               and a new fetch starts, so the song repeats and DONE is never
//               entered.
//   undefined : the block stops in DONE at the end of the song.
//
// Ports:
//   clk        in   system clock
//   nrst       in   asynchronous active-low reset
//   mode[2:0]  in   game mode; anything other than 3'd2 aborts to IDLE
//   start      in   begins (or replays) a song from IDLE or DONE
//   pause      in   freezes tick counter and index while in PLAY
//   rom_req    out  fetch request, held until rom_ack
//   rom_addr   out  word address shared by both lanes
//   rom_ack    in   one-cycle acknowledge, rom_data1/2 valid with it
//   rom_data1  in   lane-1 note word
//   rom_data2  in   lane-2 note word
//   next_note1 out  latched lane-1 word
//   next_note2 out  latched lane-2 word
//   next_idx1  out  lane-1 scroll index
//   next_idx2  out  lane-2 scroll index (always equal to next_idx1)
//   busy       out  high in FETCH or PLAY
//   song_done  out  high in DONE
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module note_scroll_sched #(
    parameter int TICK_DIV = 100000,
    parameter int LAST_IDX = 31,
    parameter int SONG_LEN = 16
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [2:0]                  mode,
    input  logic                        start,
    input  logic                        pause,
    output logic                        rom_req,
    output logic [$clog2(SONG_LEN)-1:0] rom_addr,
    input  logic                        rom_ack,
    input  logic [31:0]                 rom_data1,
    input  logic [31:0]                 rom_data2,
    output logic [31:0]                 next_note1,
    output logic [31:0]                 next_note2,
    output logic [4:0]                  next_idx1,
    output logic [4:0]                  next_idx2,
    output logic                        busy,
    output logic                        song_done
);

    localparam int AW = $clog2(SONG_LEN);
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(SONG_LEN - 1);
    localparam logic [4:0]    IDX_MAX  = 5'(LAST_IDX);
    localparam logic [2:0]    GAME_MODE = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_r;
    logic [TW-1:0] tick_r;
    logic [4:0]    idx_r;

    // Both lanes scroll in lock-step, so one index register feeds both.
    assign next_idx1 = idx_r;
    assign next_idx2 = idx_r;

    // Sequencer FSM with all datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= IDLE;
            tick_r     <= '0;
            idx_r      <= 5'd0;
            rom_req    <= 1'b0;
            rom_addr   <= '0;
            next_note1 <= 32'd0;
            next_note2 <= 32'd0;
            busy       <= 1'b0;
            song_done  <= 1'b0;
        end else if (mode != GAME_MODE) begin
            // Leaving game mode wins over everything, including start.
            state_r    <= IDLE;
            tick_r     <= '0;
            idx_r      <= 5'd0;
            rom_req    <= 1'b0;
            rom_addr   <= '0;
            next_note1 <= 32'd0;
            next_note2 <= 32'd0;
            busy       <= 1'b0;
            song_done  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r   <= FETCH;
                        rom_addr  <= '0;
                        rom_req   <= 1'b1;
                        busy      <= 1'b1;
                        song_done <= 1'b0;
                    end
                end
                FETCH: begin
                    // Index keeps showing its last value until the new word lands.
                    if (rom_ack) begin
                        next_note1 <= rom_data1;
                        next_note2 <= rom_data2;
                        idx_r      <= 5'd0;
                        tick_r     <= '0;
                        rom_req    <= 1'b0;
                        state_r    <= PLAY;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        tick_r <= tick_r;
                    end else if (tick_r != TICK_MAX) begin
                        tick_r <= tick_r + 1'b1;
                    end else begin
                        tick_r <= '0;
                        if (idx_r < IDX_MAX) begin
                            idx_r <= idx_r + 5'd1;
                        end else if (rom_addr < ADDR_MAX) begin
                            rom_addr <= rom_addr + 1'b1;
                            rom_req  <= 1'b1;
                            state_r  <= FETCH;
                        end else begin
`ifdef LOOP_EN
                            rom_addr <= '0;
                            rom_req  <= 1'b1;
                            state_r  <= FETCH;
`else
                            state_r   <= DONE;
                            busy      <= 1'b0;
                            song_done <= 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rom_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_scroll_sched.sv
// -----------------------------------------------------------------------------
// tb_note_scroll_sched
// Directed bench for note_scroll_sched with TICK_DIV=4, SONG_LEN=2,
// LAST_IDX=31. A vector table covers the fetch handshake and the first scroll
// steps; hand-written sequences cover pause, word advance, song end, replay,
// abort and asynchronous reset. The end-of-song expectation follows LOOP_EN.
// -----------------------------------------------------------------------------
module tb_note_scroll_sched;

    localparam int TICK_DIV = 4;
    localparam int LAST_IDX = 31;
    localparam int SONG_LEN = 2;
    localparam int AW       = 1;

    logic          clk;
    logic          nrst;
    logic [2:0]    mode;
    logic          start;
    logic          pause;
    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic          rom_ack;
    logic [31:0]   rom_data1;
    logic [31:0]   rom_data2;
    logic [31:0]   next_note1;
    logic [31:0]   next_note2;
    logic [4:0]    next_idx1;
    logic [4:0]    next_idx2;
    logic          busy;
    logic          song_done;

    int n_vec = 0;
    int n_err = 0;

    note_scroll_sched #(
        .TICK_DIV (TICK_DIV),
        .LAST_IDX (LAST_IDX),
        .SONG_LEN (SONG_LEN)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .mode       (mode),
        .start      (start),
        .pause      (pause),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_ack    (rom_ack),
        .rom_data1  (rom_data1),
        .rom_data2  (rom_data2),
        .next_note1 (next_note1),
        .next_note2 (next_note2),
        .next_idx1  (next_idx1),
        .next_idx2  (next_idx2),
        .busy       (busy),
        .song_done  (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    mode;
        logic          start;
        logic          pause;
        logic          ack;
        logic [31:0]   d1;
        logic [31:0]   d2;
        logic          req;
        logic [AW-1:0] addr;
        logic [31:0]   n1;
        logic [31:0]   n2;
        logic [4:0]    idx;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic req, input logic [AW-1:0] addr,
                             input logic [31:0] n1, input logic [31:0] n2,
                             input logic [4:0] idx, input logic bsy, input logic done);
        chk({tag, ".rom_req"},    {31'd0, rom_req},   {31'd0, req});
        chk({tag, ".rom_addr"},   {31'd0, rom_addr},  {31'd0, addr});
        chk({tag, ".next_note1"}, next_note1,         n1);
        chk({tag, ".next_note2"}, next_note2,         n2);
        chk({tag, ".next_idx1"},  {27'd0, next_idx1}, {27'd0, idx});
        chk({tag, ".next_idx2"},  {27'd0, next_idx2}, {27'd0, idx});
        chk({tag, ".busy"},       {31'd0, busy},      {31'd0, bsy});
        chk({tag, ".song_done"},  {31'd0, song_done}, {31'd0, done});
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [31:0] W1A = 32'hA5A5_0001;
    localparam logic [31:0] W1B = 32'h0F0F_0002;
    localparam logic [31:0] W2A = 32'h1234_5678;
    localparam logic [31:0] W2B = 32'h9ABC_DEF0;
    localparam logic [31:0] JNK = 32'hDEAD_BEEF;

    initial begin
        // Handshake and first scroll steps, one row per clock edge.
        //            mode  st    pa    ack   d1    d2    req   addr  n1    n2    idx   busy  done
        vt[0]  = '{3'd2, 1'b1, 1'b0, 1'b0, JNK,  JNK,  1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0};
        vt[1]  = '{3'd2, 1'b0, 1'b1, 1'b0, JNK,  JNK,  1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0};
        vt[2]  = '{3'd2, 1'b0, 1'b0, 1'b0, JNK,  JNK,  1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0};
        vt[3]  = '{3'd2, 1'b0, 1'b0, 1'b1, W1A,  W1B,  1'b0, 1'b0, W1A,   W1B,   5'd0, 1'b1, 1'b0};
        vt[4]  = '{3'd2, 1'b0, 1'b0, 1'b0, JNK,  JNK,  1'b0, 1'b0, W1A,   W1B,   5'd0, 1'b1, 1'b0};
        vt[5]  = '{3'd2, 1'b0, 1'b0, 1'b0, JNK,  JNK,  1'b0, 1'b0, W1A,   W1B,   5'd0, 1'b1, 1'b0};
        vt[6]  = '{3'd2, 1'b0, 1'b0, 1'b0, JNK,  JNK,  1'b0, 1'b0, W1A,   W1B,   5'd0, 1'b1, 1'b0};
        vt[7]  = '{3'd2, 1'b0, 1'b0, 1'b0, JNK,  JNK,  1'b0, 1'b0, W1A,   W1B,   5'd1, 1'b1, 1'b0};
        vt[8]  = '{3'd2, 1'b0, 1'b0, 1'b1, JNK,  JNK,  1'b0, 1'b0, W1A,   W1B,   5'd1, 1'b1, 1'b0};
        vt[9]  = '{3'd2, 1'b1, 1'b0, 1'b0, JNK,  JNK,  1'b0, 1'b0, W1A,   W1B,   5'd1, 1'b1, 1'b0};
        vt[10] = '{3'd2, 1'b0, 1'b0, 1'b0, JNK,  JNK,  1'b0, 1'b0, W1A,   W1B,   5'd1, 1'b1, 1'b0};
        vt[11] = '{3'd2, 1'b0, 1'b0, 1'b0, JNK,  JNK,  1'b0, 1'b0, W1A,   W1B,   5'd2, 1'b1, 1'b0};

        nrst = 1'b0; mode = 3'd0; start = 1'b0; pause = 1'b0;
        rom_ack = 1'b0; rom_data1 = 32'd0; rom_data2 = 32'd0;
        #12;
        check_all("reset", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        nrst = 1'b1;

        // start while not in game mode must not leave IDLE
        mode = 3'd1; start = 1'b1;
        step(1);
        check_all("abort_wins", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            mode = vt[i].mode; start = vt[i].start; pause = vt[i].pause;
            rom_ack = vt[i].ack; rom_data1 = vt[i].d1; rom_data2 = vt[i].d2;
            step(1);
            check_all($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].n1, vt[i].n2,
                      vt[i].idx, vt[i].busy, vt[i].done);
        end
        start = 1'b0; rom_ack = 1'b0;

        // Pause at tick=2 for 10 cycles, then the step lands 2 cycles later.
        step(2);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk($sformatf("pause_hold%0d", i), {27'd0, next_idx1}, 32'd2);
        end
        pause = 1'b0;
        step(1);
        chk("pause_resume1", {27'd0, next_idx1}, 32'd2);
        step(1);
        chk("pause_resume2", {27'd0, next_idx1}, 32'd3);

        // Run word 0 to its last index, then the refetch of word 1.
        step(28 * TICK_DIV);
        check_all("w0_last", 1'b0, 1'b0, W1A, W1B, 5'd31, 1'b1, 1'b0);
        step(TICK_DIV - 1);
        check_all("w0_hold", 1'b0, 1'b0, W1A, W1B, 5'd31, 1'b1, 1'b0);
        step(1);
        check_all("w1_req", 1'b1, 1'b1, W1A, W1B, 5'd31, 1'b1, 1'b0);
        step(1);
        check_all("w1_wait", 1'b1, 1'b1, W1A, W1B, 5'd31, 1'b1, 1'b0);
        rom_ack = 1'b1; rom_data1 = W2A; rom_data2 = W2B;
        step(1);
        rom_ack = 1'b0; rom_data1 = JNK; rom_data2 = JNK;
        check_all("w1_ack", 1'b0, 1'b1, W2A, W2B, 5'd0, 1'b1, 1'b0);
        step(TICK_DIV - 1);
        chk("w1_step0", {27'd0, next_idx1}, 32'd0);
        step(1);
        chk("w1_step1", {27'd0, next_idx1}, 32'd1);
        step(30 * TICK_DIV);
        chk("w1_idx31", {27'd0, next_idx1}, 32'd31);
        step(TICK_DIV - 1);
        check_all("w1_hold", 1'b0, 1'b1, W2A, W2B, 5'd31, 1'b1, 1'b0);
        step(1);
`ifdef LOOP_EN
        check_all("song_end", 1'b1, 1'b0, W2A, W2B, 5'd31, 1'b1, 1'b0);
`else
        check_all("song_end", 1'b0, 1'b1, W2A, W2B, 5'd31, 1'b0, 1'b1);
        step(3);
        check_all("done_hold", 1'b0, 1'b1, W2A, W2B, 5'd31, 1'b0, 1'b1);
`endif

        // Replay from DONE (or start ignored while already refetching).
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_all("replay", 1'b1, 1'b0, W2A, W2B, 5'd31, 1'b1, 1'b0);

        // Abort during FETCH, then a late ack must not do anything.
        mode = 3'd1;
        step(1);
        check_all("abort", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        mode = 3'd2; rom_ack = 1'b1; rom_data1 = W1A; rom_data2 = W1B;
        step(1);
        rom_ack = 1'b0;
        check_all("late_ack", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of PLAY.
        start = 1'b1;
        step(1);
        start = 1'b0; rom_ack = 1'b1;
        step(1);
        rom_ack = 1'b0;
        step(TICK_DIV + 1);
        check_all("pre_reset", 1'b0, 1'b0, W1A, W1B, 5'd1, 1'b1, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        step(1);
        nrst = 1'b1;
        step(1);
        check_all("post_reset", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_all("post_reset_start", 1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
